dcache_port_arbiter_4to2: RTL and testbench
===========================================

Name: dcache_port_arbiter_4to2

Overview:
- Shares the two physical ports of the 2-write/2-read data-cache RAM among four cache requesters in the 4-port multiported cache.
- Each cycle it grants up to two requests using round-robin priority and drives the RAM port signals.
- It suppresses same-address port conflicts.
- It routes read data back to the owning requester one cycle after grant, with a valid strobe.

Parameters:
- ADDR_W, 13, RAM word-address width.
- DATA_W, 32, word width.
- BE_W, 4, byte-enable width (DATA_W/8).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  4  request from requester i; held until granted
- we  in  4  1 = write, 0 = read, per requester
- byte_en  in  4*BE_W  byte enables; requester i at [i*BE_W +: BE_W]
- addr  in  4*ADDR_W  word address per requester
- write_data  in  4*DATA_W  write data per requester
- gnt  out  4  combinational grant, same cycle as the accepted request
- rd_valid  out  4  read data for requester i valid this cycle (registered)
- rd_data  out  4*DATA_W  read data per requester; zero when rd_valid[i]=0
- mem_write_en_0/1  out  1  RAM port write enables
- mem_byte_en_0/1  out  BE_W  RAM port byte enables
- mem_addr_0/1  out  ADDR_W  RAM port addresses
- mem_write_data_0/1  out  DATA_W  RAM port write data
- mem_read_data_0/1  in  DATA_W  RAM q outputs, valid one cycle after address presented

Behaviour:
- State:
  - 2-bit round-robin pointer ptr.
  - Per-port read tags tag_v0/1 (1 bit) and tag_id0/1 (2 bits).
- Reset (async): ptr=0, tag_v0=tag_v1=0, tag_id=0. While reset is asserted: gnt=0, rd_valid=0, rd_data=0, all mem_* outputs 0.
- Candidate selection (combinational):
  - Scan requesters ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - First asserted req = candidate A, which goes to port 0.
  - Next asserted req = candidate B, which goes to port 1, unless A and B have equal addr and at least one is a write. In that case B is deferred, and no other requester is substituted for it this cycle.
  - Two reads to the same address are both granted.
- gnt[i]=1 exactly for the granted A and B; at most two bits set.
- Idle port: mem_write_en=0, byte_en=0, addr=0, write_data=0.
- Granted port: mem_write_en=we[i], mem_byte_en=byte_en[i] for writes and all-ones for reads, mem_addr=addr[i], mem_write_data=write_data[i].
- Pointer update:
  - If any grant, ptr <= (last granted index)+1 mod 4, where last granted is B if granted, else A.
  - If no grant, ptr holds.
- Read return:
  - On grant of a read on port p: tag_vp<=1, tag_idp<=i. Otherwise tag_vp<=0.
  - Next cycle: rd_valid[tag_idp]=tag_vp and rd_data slice = mem_read_data_p. Other slices are 0.
  - Both tags may target different requesters in the same cycle.
- Write completion: the write is complete at the gnt cycle; no rd_valid is produced for writes.
- Latency: gnt is combinational (0 cycles); read data arrives exactly 1 cycle after gnt.
- A requester may issue a new request in the cycle after its grant.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data, because RAM ordering is preserved.
- Reset mid-operation: pending tags are cleared and the in-flight rd_valid is dropped. Requesters must reissue.

Test Plan:
- Reset, then req=4'b0001 read addr 5, RAM preloaded 0xDEAD_BEEF -> gnt=0001 and port0 addr=5 in the same cycle; next cycle rd_valid=0001 and rd_data[0]=0xDEADBEEF.
- All four req asserted as reads, distinct addresses, held -> cycle 1 gnt=0011 (ptr 0→2), cycle 2 gnt=1100 (ptr→0); rd_valid follows each one cycle later with correct data per requester.
- req0 write addr 9 data 0x11223344 be=1111, with req1 read addr 9 in the same cycle (ptr=0) -> gnt=0001 only. Next cycle req1 is granted, and one cycle later rd_data[1]=0x11223344.
- req2 and req3 both read addr 7, ptr=2 -> gnt=1100, both rd_valid next cycle with identical data.
- byte_en=0010 write 0xAABBCCDD over 0x00000000, then read -> 0x0000CC00.
- Assert reset the cycle after a read grant -> rd_valid stays 0, ptr=0, all mem_* outputs 0 during reset.

Source files
------------

// File: rtl/dcache_port_arbiter_4to2_if.sv
// Requester and RAM-port bundle for the 4-requester / 2-port data-cache arbiter.
// master = requesters plus RAM model side, slave = arbiter side.
interface dcache_port_arbiter_4to2_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
);
  localparam int unsigned NREQ = 4;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*BE_W-1:0]   byte_en;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] write_data;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [NREQ*DATA_W-1:0] rd_data;

  logic                   mem_write_en_0;
  logic                   mem_write_en_1;
  logic [BE_W-1:0]        mem_byte_en_0;
  logic [BE_W-1:0]        mem_byte_en_1;
  logic [ADDR_W-1:0]      mem_addr_0;
  logic [ADDR_W-1:0]      mem_addr_1;
  logic [DATA_W-1:0]      mem_write_data_0;
  logic [DATA_W-1:0]      mem_write_data_1;
  logic [DATA_W-1:0]      mem_read_data_0;
  logic [DATA_W-1:0]      mem_read_data_1;

  modport master (
    output req, we, byte_en, addr, write_data, mem_read_data_0, mem_read_data_1,
    input  gnt, rd_valid, rd_data,
    input  mem_write_en_0, mem_write_en_1, mem_byte_en_0, mem_byte_en_1,
    input  mem_addr_0, mem_addr_1, mem_write_data_0, mem_write_data_1
  );

  modport slave (
    input  req, we, byte_en, addr, write_data, mem_read_data_0, mem_read_data_1,
    output gnt, rd_valid, rd_data,
    output mem_write_en_0, mem_write_en_1, mem_byte_en_0, mem_byte_en_1,
    output mem_addr_0, mem_addr_1, mem_write_data_0, mem_write_data_1
  );
endinterface

// File: rtl/dcache_port_arbiter_4to2.sv
// Round-robin arbiter granting up to two of four cache requesters onto the two
// RAM ports, with same-address write conflict deferral and tagged read return.
module dcache_port_arbiter_4to2 #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  dcache_port_arbiter_4to2_if.slave bus
);
  localparam int unsigned NREQ = 4;
  typedef logic [1:0] idx_t;

  logic [ADDR_W-1:0] req_addr [NREQ];
  logic [BE_W-1:0]   req_be   [NREQ];
  logic [DATA_W-1:0] req_wd   [NREQ];
  logic [DATA_W-1:0] rd_word  [NREQ];

  idx_t ptr_q, ptr_d;
  logic tag_v0_q, tag_v0_d, tag_v1_q, tag_v1_d;
  idx_t tag_id0_q, tag_id0_d, tag_id1_q, tag_id1_d;

  logic a_vld, b_vld, b_conflict, gnt_a, gnt_b;
  idx_t a_idx, b_idx, scan_idx;

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_addr[k] = bus.addr[k*ADDR_W +: ADDR_W];
      req_be[k]   = bus.byte_en[k*BE_W +: BE_W];
      req_wd[k]   = bus.write_data[k*DATA_W +: DATA_W];
    end
  end

  // First two asserted requests in rotating order starting at ptr_q.
  always_comb begin
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + idx_t'(k);
      if (bus.req[scan_idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = scan_idx;
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = scan_idx;
        end
      end
    end
  end

  assign b_conflict = (req_addr[a_idx] == req_addr[b_idx]) && (bus.we[a_idx] || bus.we[b_idx]);
  assign gnt_a      = a_vld && !reset;
  assign gnt_b      = b_vld && !b_conflict && !reset;

  always_comb begin
    bus.gnt = '0;
    if (gnt_a) bus.gnt[a_idx] = 1'b1;
    if (gnt_b) bus.gnt[b_idx] = 1'b1;
  end

  // Reads use all byte lanes; idle ports drive zeros.
  always_comb begin
    bus.mem_write_en_0   = 1'b0;
    bus.mem_byte_en_0    = '0;
    bus.mem_addr_0       = '0;
    bus.mem_write_data_0 = '0;
    bus.mem_write_en_1   = 1'b0;
    bus.mem_byte_en_1    = '0;
    bus.mem_addr_1       = '0;
    bus.mem_write_data_1 = '0;
    if (gnt_a) begin
      bus.mem_write_en_0   = bus.we[a_idx];
      bus.mem_byte_en_0    = bus.we[a_idx] ? req_be[a_idx] : {BE_W{1'b1}};
      bus.mem_addr_0       = req_addr[a_idx];
      bus.mem_write_data_0 = req_wd[a_idx];
    end
    if (gnt_b) begin
      bus.mem_write_en_1   = bus.we[b_idx];
      bus.mem_byte_en_1    = bus.we[b_idx] ? req_be[b_idx] : {BE_W{1'b1}};
      bus.mem_addr_1       = req_addr[b_idx];
      bus.mem_write_data_1 = req_wd[b_idx];
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    tag_v0_d  = gnt_a && !bus.we[a_idx];
    tag_id0_d = gnt_a ? a_idx : idx_t'(0);
    tag_v1_d  = gnt_b && !bus.we[b_idx];
    tag_id1_d = gnt_b ? b_idx : idx_t'(0);
    if (gnt_b)      ptr_d = b_idx + idx_t'(1);
    else if (gnt_a) ptr_d = a_idx + idx_t'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      tag_v0_q  <= 1'b0;
      tag_v1_q  <= 1'b0;
      tag_id0_q <= '0;
      tag_id1_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tag_v0_q  <= tag_v0_d;
      tag_v1_q  <= tag_v1_d;
      tag_id0_q <= tag_id0_d;
      tag_id1_q <= tag_id1_d;
    end
  end

  // Route RAM q of each port to the requester that owned it last cycle.
  always_comb begin
    bus.rd_valid = '0;
    for (int unsigned k = 0; k < NREQ; k++) rd_word[k] = '0;
    if (tag_v0_q) begin
      bus.rd_valid[tag_id0_q] = 1'b1;
      rd_word[tag_id0_q]      = bus.mem_read_data_0;
    end
    if (tag_v1_q) begin
      bus.rd_valid[tag_id1_q] = 1'b1;
      rd_word[tag_id1_q]      = bus.mem_read_data_1;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) bus.rd_data[k*DATA_W +: DATA_W] = rd_word[k];
  end
endmodule

// File: tb/tb_dcache_port_arbiter_4to2.sv
// Bench for dcache_port_arbiter_4to2: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based reference model and a RAM model.
module tb_dcache_port_arbiter_4to2;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned PORT_W = 1 + BE_W + ADDR_W + DATA_W;
  localparam int unsigned N_RAND = 3000;

  logic clock;
  logic reset;

  dcache_port_arbiter_4to2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  dcache_port_arbiter_4to2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester stimulus state
  logic [3:0]        r_req, r_we;
  logic [BE_W-1:0]   r_be   [4];
  logic [ADDR_W-1:0] r_addr [4];
  logic [DATA_W-1:0] r_wd   [4];

  // RAM contents (environment) and reference model state
  logic [DATA_W-1:0] ram   [DEPTH];
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_ptr;
  int                g_last[$];
  logic [3:0]        exp_gnt, cur_rdv, nxt_rdv;
  logic [DATA_W-1:0] cur_rdd [4];
  logic [DATA_W-1:0] nxt_rdd [4];

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req[i]                         = r_req[i];
      bus.we[i]                          = r_we[i];
      bus.byte_en[i*BE_W +: BE_W]        = r_be[i];
      bus.addr[i*ADDR_W +: ADDR_W]       = r_addr[i];
      bus.write_data[i*DATA_W +: DATA_W] = r_wd[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    r_req[i] = 1'b1; r_we[i] = we; r_be[i] = be; r_addr[i] = a; r_wd[i] = d;
  endtask

  // Model: take the first two requesters in rotating order, defer the second on a write-involved address clash.
  task automatic eval_and_check();
    int order[$];
    logic [PORT_W-1:0] exp_port [2];
    logic [PORT_W-1:0] act_port [2];
    logic [4*DATA_W-1:0] exp_rd;
    @(negedge clock);
    if (reset) begin
      cur_rdv = '0;
      for (int i = 0; i < 4; i++) cur_rdd[i] = '0;
    end
    g_last.delete();
    for (int k = 0; k < 4; k++) if (r_req[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    if (!reset && order.size() > 0) g_last.push_back(order[0]);
    if (!reset && order.size() > 1 &&
        !(r_addr[order[0]] == r_addr[order[1]] && (r_we[order[0]] || r_we[order[1]])))
      g_last.push_back(order[1]);
    exp_gnt = '0;
    nxt_rdv = '0;
    exp_port[0] = '0;
    exp_port[1] = '0;
    for (int i = 0; i < 4; i++) nxt_rdd[i] = '0;
    foreach (g_last[p]) begin
      int i;
      i = g_last[p];
      exp_gnt[i]  = 1'b1;
      exp_port[p] = {r_we[i], (r_we[i] ? r_be[i] : {BE_W{1'b1}}), r_addr[i], r_wd[i]};
      if (!r_we[i]) begin
        nxt_rdv[i] = 1'b1;
        nxt_rdd[i] = m_mem[r_addr[i]];
      end
    end
    for (int i = 0; i < 4; i++) exp_rd[i*DATA_W +: DATA_W] = cur_rdd[i];
    act_port[0] = {bus.mem_write_en_0, bus.mem_byte_en_0, bus.mem_addr_0, bus.mem_write_data_0};
    act_port[1] = {bus.mem_write_en_1, bus.mem_byte_en_1, bus.mem_addr_1, bus.mem_write_data_1};
    check("gnt", bus.gnt, exp_gnt);
    check("port0", act_port[0], exp_port[0]);
    check("port1", act_port[1], exp_port[1]);
    check("rd_valid", bus.rd_valid, cur_rdv);
    check("rd_data", bus.rd_data, exp_rd);
  endtask

  // Clock edge: RAM reads then writes what the DUT drives; model commits grants.
  task automatic advance();
    logic              we0, we1;
    logic [BE_W-1:0]   be0, be1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    we0 = bus.mem_write_en_0; be0 = bus.mem_byte_en_0; a0 = bus.mem_addr_0; d0 = bus.mem_write_data_0;
    we1 = bus.mem_write_en_1; be1 = bus.mem_byte_en_1; a1 = bus.mem_addr_1; d1 = bus.mem_write_data_1;
    @(posedge clock);
    bus.mem_read_data_0 = ram[a0];
    bus.mem_read_data_1 = ram[a1];
    if (we0) ram[a0] = merge(ram[a0], d0, be0);
    if (we1) ram[a1] = merge(ram[a1], d1, be1);
    foreach (g_last[p]) begin
      int i;
      i = g_last[p];
      if (r_we[i]) m_mem[r_addr[i]] = merge(m_mem[r_addr[i]], r_wd[i], r_be[i]);
    end
    if (g_last.size() > 0) m_ptr = (g_last[g_last.size() - 1] + 1) % 4;
    cur_rdv = nxt_rdv;
    for (int i = 0; i < 4; i++) cur_rdd[i] = nxt_rdd[i];
    if (reset) begin
      m_ptr   = 0;
      cur_rdv = '0;
      for (int i = 0; i < 4; i++) cur_rdd[i] = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_req = '0;
    drive();
    eval_and_check();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    m_ptr    = 0;
    cur_rdv  = '0;
    nxt_rdv  = '0;
    r_req    = '0;
    r_we     = '0;
    for (int i = 0; i < 4; i++) begin
      r_be[i] = '0; r_addr[i] = '0; r_wd[i] = '0; cur_rdd[i] = '0; nxt_rdd[i] = '0;
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      ram[a] = '0;
      m_mem[a] = '0;
    end
    bus.mem_read_data_0 = '0;
    bus.mem_read_data_1 = '0;
    ram[5] = 32'hDEAD_BEEF; m_mem[5] = 32'hDEAD_BEEF;
    ram[7] = 32'h0707_0707; m_mem[7] = 32'h0707_0707;
    for (int i = 0; i < 4; i++) begin
      ram[10 + i]   = 32'hA000_0000 + 32'(i);
      m_mem[10 + i] = 32'hA000_0000 + 32'(i);
    end
    drive();
    do_reset();

    // Single read, data one cycle later
    set_req(0, 1'b0, 4'h0, 13'd5, 32'h0);
    drive();
    eval_and_check();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_addr0", bus.mem_addr_0, 13'd5);
    advance();
    r_req = '0; drive();
    eval_and_check();
    check("t1_rdv", bus.rd_valid, 4'b0001);
    check("t1_rdd", bus.rd_data[31:0], 32'hDEAD_BEEF);
    advance();

    // Four reads held: two per cycle in rotation
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'h0, 13'(10 + i), 32'h0);
    drive();
    eval_and_check();
    check("t2_gnt_a", bus.gnt, 4'b0011);
    advance();
    r_req = 4'b1100; drive();
    eval_and_check();
    check("t2_gnt_b", bus.gnt, 4'b1100);
    check("t2_rdv_a", bus.rd_valid, 4'b0011);
    advance();
    r_req = '0; drive();
    eval_and_check();
    check("t2_rdv_b", bus.rd_valid, 4'b1100);
    check("t2_rdd3", bus.rd_data[127:96], 32'hA000_0003);
    advance();

    // Write/read clash on one address defers the read
    do_reset();
    set_req(0, 1'b1, 4'hF, 13'd9, 32'h1122_3344);
    set_req(1, 1'b0, 4'h0, 13'd9, 32'h0);
    drive();
    eval_and_check();
    check("t3_gnt_w", bus.gnt, 4'b0001);
    advance();
    r_req = 4'b0010; drive();
    eval_and_check();
    check("t3_gnt_r", bus.gnt, 4'b0010);
    advance();
    r_req = '0; drive();
    eval_and_check();
    check("t3_rdd1", bus.rd_data[63:32], 32'h1122_3344);
    advance();

    // Two reads of the same address, ptr at 2
    set_req(2, 1'b0, 4'h0, 13'd7, 32'h0);
    set_req(3, 1'b0, 4'h0, 13'd7, 32'h0);
    drive();
    eval_and_check();
    check("t4_gnt", bus.gnt, 4'b1100);
    advance();
    r_req = '0; drive();
    eval_and_check();
    check("t4_rdv", bus.rd_valid, 4'b1100);
    check("t4_rdd2", bus.rd_data[95:64], 32'h0707_0707);
    check("t4_rdd3", bus.rd_data[127:96], 32'h0707_0707);
    advance();

    // Partial byte write then readback
    set_req(0, 1'b1, 4'b0010, 13'd20, 32'hAABB_CCDD);
    drive();
    eval_and_check();
    advance();
    set_req(0, 1'b0, 4'h0, 13'd20, 32'h0);
    drive();
    eval_and_check();
    advance();
    r_req = '0; drive();
    eval_and_check();
    check("t5_rdd", bus.rd_data[31:0], 32'h0000_CC00);
    advance();

    // Reset right after a read grant drops the return
    set_req(0, 1'b0, 4'h0, 13'd5, 32'h0);
    drive();
    eval_and_check();
    advance();
    reset = 1'b1;
    eval_and_check();
    check("t6_rdv", bus.rd_valid, 4'b0000);
    check("t6_gnt", bus.gnt, 4'b0000);
    check("t6_mem", {bus.mem_write_en_0, bus.mem_byte_en_0, bus.mem_addr_0, bus.mem_write_data_0,
                     bus.mem_write_en_1, bus.mem_byte_en_1, bus.mem_addr_1, bus.mem_write_data_1}, '0);
    advance();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'h0, 13'(10 + i), 32'h0);
    drive();
    eval_and_check();
    check("t6_ptr0", bus.gnt, 4'b0011);
    advance();

    // Random traffic: granted or idle requesters may pick a new request
    for (int c = 0; c < int'(N_RAND); c++) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_gnt[i] || !r_req[i]) begin
          if ($urandom_range(0, 9) < 6)
            set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), 13'($urandom_range(0, 15)), $urandom);
          else
            r_req[i] = 1'b0;
        end
      end
      drive();
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        eval_and_check();
        advance();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
